// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcode and state
// encodings, widths, and the packed control-strobe bundle driven by the FSM.
package cpu_pkg;

   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned WAIT_W   = 8;

   typedef enum logic [OPCODE_W-1:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_t;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_INC_PC = 4'd2,
      ST_DECODE = 4'd3,
      ST_RDOP   = 4'd4,
      ST_WROP   = 4'd5,
      ST_JUMP   = 4'd6,
      ST_SKIP   = 4'd7,
      ST_HALT   = 4'd8,
      ST_FAULT  = 4'd9
   } state_t;

   // Control strobes decoded from the current state
   typedef struct packed {
      logic pc_en;
      logic pc_in;
      logic pc_src;
      logic addr_sel;
      logic mem_rd;
      logic mem_wr;
      logic ir_load;
      logic acc_load;
      logic halted;
      logic fault;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   // States that hold a memory access open and therefore count wait cycles
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_RDOP) || (s == ST_WROP);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle watchdog. Counts consecutive cycles in which an access is
// open but memory has not answered; flags expiry on the cycle whose wait would
// bring the count to MEM_WAIT_MAX, so the FSM faults on the following cycle.
// MEM_WAIT_MAX = 0 disables expiry.
//   clock     : system clock, rising edge
//   rst       : asynchronous active-low reset
//   active    : an access is open this cycle
//   mem_ready : memory completes the access this cycle
//   expired   : wait limit reached (combinational)
module mem_wait_timer
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic clock,
   input  logic rst,
   input  logic active,
   input  logic mem_ready,
   output logic expired
);

   localparam logic [WAIT_W-1:0] LAST_WAIT =
      (MEM_WAIT_MAX == 0) ? '0 : WAIT_W'(MEM_WAIT_MAX - 1);

   logic [WAIT_W-1:0] count;

   // Saturating count of consecutive unanswered access cycles
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (!active || mem_ready) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + WAIT_W'(1);
      end
   end

   assign expired = (MEM_WAIT_MAX != 0) && active && !mem_ready && (count == LAST_WAIT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for an 8-bit accumulator CPU. Sequences
// fetch / PC increment / decode / operand access, and handles halt, skip,
// jump and a memory-timeout fault. Strobes are decoded from state and
// mem_ready; alu_op is captured in DECODE.
//   clock, rst        : rising-edge clock, asynchronous active-low reset
//   run               : start/resume request, rising edge significant
//   opcode, zero      : IR[7:5] and accumulator-zero flag
//   mem_ready         : memory completes the access this cycle
//   pc_en/pc_in/pc_src: program-counter enable, load, source select
//   addr_sel          : address mux (0 = PC, 1 = IR[4:0])
//   mem_rd/mem_wr     : memory read/write request
//   ir_load/acc_load  : IR and accumulator capture strobes
//   alu_op            : opcode latched in DECODE
//   halted, fault     : status
module control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic                pc_in,
   output logic                pc_src,
   output logic                addr_sel,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                ir_load,
   output logic                acc_load,
   output logic [OPCODE_W-1:0] alu_op,
   output logic                halted,
   output logic                fault
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl;
   logic   run_q;
   logic   run_rise;
   logic   wait_expired;

   assign run_rise = run && !run_q;

   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX)
   ) u_wait_timer (
      .clock     (clock),
      .rst       (rst),
      .active    (is_mem_state(state)),
      .mem_ready (mem_ready),
      .expired   (wait_expired)
   );

   // State, run history and latched ALU operation
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         run_q  <= 1'b0;
         alu_op <= '0;
      end else begin
         state <= next_state;
         run_q <= run;
         if (state == ST_DECODE) begin
            alu_op <= opcode;
         end
      end
   end

   // Next-state and strobe decode
   always_comb begin
      next_state = state;
      ctrl       = CTRL_NONE;
      unique case (state)
         ST_IDLE: begin
            if (run_rise) next_state = ST_FETCH;
         end
         ST_FETCH: begin
            ctrl.mem_rd = 1'b1;
            if (mem_ready) begin
               ctrl.ir_load = 1'b1;
               next_state   = ST_INC_PC;
            end else if (wait_expired) begin
               next_state = ST_FAULT;
            end
         end
         ST_INC_PC: begin
            ctrl.pc_en = 1'b1;
            ctrl.pc_in = 1'b1;
            next_state = ST_DECODE;
         end
         ST_DECODE: begin
            unique case (opcode_t'(opcode))
               OP_HLT: next_state = ST_HALT;
               OP_SKZ: next_state = zero ? ST_SKIP : ST_FETCH;
               OP_JMP: next_state = ST_JUMP;
               OP_STO: next_state = ST_WROP;
               OP_ADD, OP_AND, OP_XOR, OP_LDA: next_state = ST_RDOP;
            endcase
         end
         ST_RDOP: begin
            ctrl.mem_rd   = 1'b1;
            ctrl.addr_sel = 1'b1;
            if (mem_ready) begin
               ctrl.acc_load = 1'b1;
               next_state    = ST_FETCH;
            end else if (wait_expired) begin
               next_state = ST_FAULT;
            end
         end
         ST_WROP: begin
            ctrl.mem_wr   = 1'b1;
            ctrl.addr_sel = 1'b1;
            if (mem_ready) begin
               next_state = ST_FETCH;
            end else if (wait_expired) begin
               next_state = ST_FAULT;
            end
         end
         ST_JUMP: begin
            ctrl.pc_en  = 1'b1;
            ctrl.pc_in  = 1'b1;
            ctrl.pc_src = 1'b1;
            next_state  = ST_FETCH;
         end
         ST_SKIP: begin
            ctrl.pc_en = 1'b1;
            ctrl.pc_in = 1'b1;
            next_state = ST_FETCH;
         end
         ST_HALT: begin
            ctrl.halted = 1'b1;
            if (run_rise) next_state = ST_FETCH;
         end
         ST_FAULT: begin
            ctrl.fault = 1'b1;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign pc_en    = ctrl.pc_en;
   assign pc_in    = ctrl.pc_in;
   assign pc_src   = ctrl.pc_src;
   assign addr_sel = ctrl.addr_sel;
   assign mem_rd   = ctrl.mem_rd;
   assign mem_wr   = ctrl.mem_wr;
   assign ir_load  = ctrl.ir_load;
   assign acc_load = ctrl.acc_load;
   assign halted   = ctrl.halted;
   assign fault    = ctrl.fault;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit. A second instance with the wait
// timeout disabled covers the no-fault case.
module tb_control_unit;

   logic       clock;
   logic       rst;
   logic       run;
   logic [2:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, pc_in, pc_src, addr_sel, mem_rd, mem_wr;
   logic       ir_load, acc_load, halted, fault;
   logic [2:0] alu_op;

   logic       rst0, run0, mem_ready0;
   logic       pc_en0, pc_in0, pc_src0, addr_sel0, mem_rd0, mem_wr0;
   logic       ir_load0, acc_load0, halted0, fault0;
   logic [2:0] alu_op0;

   int checks = 0;
   int errors = 0;

   // Strobe vector: pc_en pc_in pc_src addr_sel mem_rd mem_wr ir_load acc_load halted fault
   logic [9:0] obs;
   assign obs = {pc_en, pc_in, pc_src, addr_sel, mem_rd, mem_wr, ir_load, acc_load, halted, fault};

   localparam logic [9:0] O_IDLE    = 10'b0000000000;
   localparam logic [9:0] O_FETCH_R = 10'b0000101000;
   localparam logic [9:0] O_FETCH_W = 10'b0000100000;
   localparam logic [9:0] O_INC     = 10'b1100000000;
   localparam logic [9:0] O_DEC     = 10'b0000000000;
   localparam logic [9:0] O_RDOP_R  = 10'b0001100100;
   localparam logic [9:0] O_RDOP_W  = 10'b0001100000;
   localparam logic [9:0] O_WROP    = 10'b0001010000;
   localparam logic [9:0] O_JUMP    = 10'b1110000000;
   localparam logic [9:0] O_SKIP    = 10'b1100000000;
   localparam logic [9:0] O_HALT    = 10'b0000000010;
   localparam logic [9:0] O_FAULT   = 10'b0000000001;

   control_unit #(.MEM_WAIT_MAX(15)) dut (
      .clock(clock), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .pc_in(pc_in), .pc_src(pc_src),
      .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load),
      .acc_load(acc_load), .alu_op(alu_op), .halted(halted), .fault(fault)
   );

   control_unit #(.MEM_WAIT_MAX(0)) dut0 (
      .clock(clock), .rst(rst0), .run(run0), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready0), .pc_en(pc_en0), .pc_in(pc_in0), .pc_src(pc_src0),
      .addr_sel(addr_sel0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .ir_load(ir_load0),
      .acc_load(acc_load0), .alu_op(alu_op0), .halted(halted0), .fault(fault0)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Single-cycle run pulse; returns one cycle later at the start of FETCH
   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (obs !== O_IDLE) begin $display("FAIL reset_outputs: got %b want %b", obs, O_IDLE); errors++; end
      checks++;
      if (alu_op !== 3'b000) begin $display("FAIL reset_alu_op: got %b want 000", alu_op); errors++; end
      tick();
      tick();
      rst  = 1'b1;
      rst0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs !== O_IDLE) begin $display("FAIL idle_no_run cycle %0d: got %b want %b", i, obs, O_IDLE); errors++; end
      end
   endtask

   task automatic test_add();
      logic [9:0] exp [8];
      exp = '{O_FETCH_R, O_INC, O_DEC, O_RDOP_R, O_FETCH_R, O_INC, O_DEC, O_HALT};
      opcode    = 3'b010;
      mem_ready = 1'b1;
      pulse_run();
      for (int i = 0; i < 8; i++) begin
         if (i == 4) opcode = 3'b000;
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL add cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         if (i == 3) begin
            checks++;
            if (alu_op !== 3'b010) begin $display("FAIL add_alu_op: got %b want 010", alu_op); errors++; end
         end
         if (i == 7) begin
            checks++;
            if (alu_op !== 3'b000) begin $display("FAIL hlt_alu_op: got %b want 000", alu_op); errors++; end
         end
         tick();
      end
   endtask

   task automatic test_jmp();
      logic [9:0] exp [8];
      exp = '{O_FETCH_R, O_INC, O_DEC, O_JUMP, O_FETCH_R, O_INC, O_DEC, O_HALT};
      opcode = 3'b111;
      pulse_run();
      for (int i = 0; i < 8; i++) begin
         if (i == 4) opcode = 3'b000;
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL jmp cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         if (i == 3) begin
            checks++;
            if (alu_op !== 3'b111) begin $display("FAIL jmp_alu_op: got %b want 111", alu_op); errors++; end
         end
         tick();
      end
   endtask

   task automatic test_skz();
      logic [9:0] taken [8];
      logic [9:0] fall [7];
      taken = '{O_FETCH_R, O_INC, O_DEC, O_SKIP, O_FETCH_R, O_INC, O_DEC, O_HALT};
      fall  = '{O_FETCH_R, O_INC, O_DEC, O_FETCH_R, O_INC, O_DEC, O_HALT};
      opcode = 3'b001;
      zero   = 1'b1;
      pulse_run();
      for (int i = 0; i < 8; i++) begin
         if (i == 4) opcode = 3'b000;
         #1;
         checks++;
         if (obs !== taken[i]) begin $display("FAIL skz_taken cycle %0d: got %b want %b", i + 1, obs, taken[i]); errors++; end
         tick();
      end
      opcode = 3'b001;
      zero   = 1'b0;
      pulse_run();
      for (int i = 0; i < 7; i++) begin
         if (i == 3) opcode = 3'b000;
         #1;
         checks++;
         if (obs !== fall[i]) begin $display("FAIL skz_not_taken cycle %0d: got %b want %b", i + 1, obs, fall[i]); errors++; end
         tick();
      end
   endtask

   task automatic test_mem_wait();
      logic [9:0] exp [10];
      logic       rdy [10];
      // Store with two wait cycles in WROP
      exp = '{O_FETCH_R, O_INC, O_DEC, O_WROP, O_WROP, O_WROP, O_FETCH_R, O_INC, O_DEC, O_HALT};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      opcode = 3'b110;
      pulse_run();
      for (int i = 0; i < 10; i++) begin
         if (i == 6) opcode = 3'b000;
         mem_ready = rdy[i];
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL sto_wait cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         tick();
      end
      // Load with one wait cycle in FETCH and one in RDOP
      exp = '{O_FETCH_W, O_FETCH_R, O_INC, O_DEC, O_RDOP_W, O_RDOP_R, O_FETCH_R, O_INC, O_DEC, O_HALT};
      rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      opcode = 3'b101;
      pulse_run();
      for (int i = 0; i < 10; i++) begin
         if (i == 6) opcode = 3'b000;
         mem_ready = rdy[i];
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL lda_wait cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         tick();
      end
   endtask

   task automatic test_halt_hold();
      logic [9:0] exp [4];
      exp = '{O_FETCH_R, O_INC, O_DEC, O_HALT};
      opcode    = 3'b000;
      mem_ready = 1'b1;
      run       = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL halt_entry cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if (obs !== O_HALT) begin $display("FAIL halt_hold cycle %0d: got %b want %b", i, obs, O_HALT); errors++; end
         tick();
      end
      run = 1'b0;
      #1;
      checks++;
      if (obs !== O_HALT) begin $display("FAIL halt_run_low: got %b want %b", obs, O_HALT); errors++; end
      tick();
      pulse_run();
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL halt_resume cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         tick();
      end
   endtask

   task automatic test_fault();
      opcode    = 3'b000;
      mem_ready = 1'b0;
      pulse_run();
      for (int i = 0; i < 15; i++) begin
         #1;
         checks++;
         if (obs !== O_FETCH_W) begin $display("FAIL fault_wait cycle %0d: got %b want %b", i + 1, obs, O_FETCH_W); errors++; end
         tick();
      end
      #1;
      checks++;
      if (obs !== O_FAULT) begin $display("FAIL fault_entry: got %b want %b", obs, O_FAULT); errors++; end
      mem_ready = 1'b1;
      tick();
      pulse_run();
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (obs !== O_FAULT) begin $display("FAIL fault_sticky cycle %0d: got %b want %b", i, obs, O_FAULT); errors++; end
         tick();
      end
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== O_IDLE) begin $display("FAIL fault_reset: got %b want %b", obs, O_IDLE); errors++; end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_no_timeout();
      logic bad;
      bad        = 1'b0;
      mem_ready0 = 1'b0;
      run0       = 1'b1;
      tick();
      run0 = 1'b0;
      for (int i = 0; i < 300 && !bad; i++) begin
         #1;
         checks++;
         if (fault0 !== 1'b0 || mem_rd0 !== 1'b1) begin
            $display("FAIL no_timeout cycle %0d: got fault=%b mem_rd=%b want fault=0 mem_rd=1", i, fault0, mem_rd0);
            errors++;
            bad = 1'b1;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_wrop();
      logic [9:0] exp [3];
      exp = '{O_FETCH_R, O_INC, O_DEC};
      opcode    = 3'b110;
      mem_ready = 1'b1;
      pulse_run();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (obs !== exp[i]) begin $display("FAIL wrop_entry cycle %0d: got %b want %b", i + 1, obs, exp[i]); errors++; end
         tick();
      end
      mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== O_WROP) begin $display("FAIL wrop_active: got %b want %b", obs, O_WROP); errors++; end
      rst = 1'b0;
      #1;
      checks++;
      if (mem_wr !== 1'b0 || obs !== O_IDLE) begin $display("FAIL wrop_async_reset: got %b want %b", obs, O_IDLE); errors++; end
      checks++;
      if (alu_op !== 3'b000) begin $display("FAIL wrop_reset_alu_op: got %b want 000", alu_op); errors++; end
      tick();
      rst       = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== O_IDLE) begin $display("FAIL post_reset_idle cycle %0d: got %b want %b", i, obs, O_IDLE); errors++; end
      end
      pulse_run();
      #1;
      checks++;
      if (obs !== O_FETCH_R) begin $display("FAIL post_reset_fetch: got %b want %b", obs, O_FETCH_R); errors++; end
   endtask

   initial begin
      rst        = 1'b0;
      run        = 1'b0;
      opcode     = 3'b000;
      zero       = 1'b0;
      mem_ready  = 1'b0;
      rst0       = 1'b0;
      run0       = 1'b0;
      mem_ready0 = 1'b0;
      test_reset();
      test_add();
      test_jmp();
      test_skz();
      test_mem_wait();
      test_halt_hold();
      test_fault();
      test_no_timeout();
      test_reset_mid_wrop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
